gf256_mul_pipe: RTL and testbench



---
 rtl/kuz_gf_pkg.sv | 76 +++++++
 rtl/gf256_mul_lane.sv | 83 ++++++++
 rtl/gf256_mul_pipe.sv | 145 ++++++++++++++
 tb/tb_gf256_mul_pipe.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/kuz_gf_pkg.sv
`default_nettype none
// ============================================================================
// Module      : kuz_gf_pkg
// Description : Shared GF(2^8) types, field polynomial, log/antilog table
//               generators and a shift-and-add reference multiplier for the
//               Kuznechik L/R transform datapath.
// Revision    : 1.0 - initial release
// ============================================================================
package kuz_gf_pkg;

  // Kuznechik field polynomial x^8+x^7+x^6+x+1
  localparam logic [8:0] KUZ_POLY = 9'h1C3;

  typedef logic [7:0] gf_byte_t;

  // 256-entry byte table, packed so it can be a function return value and a
  // localparam without relying on unpacked-array constant folding.
  typedef logic [255:0][7:0] gf_tab_t;

  // Multiply by the generator 0x02 and reduce modulo poly.
  function automatic gf_byte_t gf_xtime(input gf_byte_t x, input logic [8:0] poly);
    logic [8:0] t;
    t = {x, 1'b0};
    if (t[8]) begin
      t = t ^ poly;
    end
    return t[7:0];
  endfunction

  // exp table: entry k holds g^k for k in 0..254. Entry 255 aliases g^0 and
  // is never addressed because the exponent sum is reduced to 0..254.
  function automatic gf_tab_t gf_exp_tab(input logic [8:0] poly);
    gf_tab_t  tab;
    gf_byte_t e;
    tab = '0;
    e   = 8'h01;
    for (int k = 0; k < 255; k++) begin
      tab[k[7:0]] = e;
      e           = gf_xtime(e, poly);
    end
    tab[255] = 8'h01;
    return tab;
  endfunction

  // log table: entry g^k holds k. Entry 0 is a don't-care (left at 0); the
  // datapath carries a separate zero flag instead of using it.
  function automatic gf_tab_t gf_log_tab(input logic [8:0] poly);
    gf_tab_t  tab;
    gf_byte_t e;
    tab = '0;
    e   = 8'h01;
    for (int k = 0; k < 255; k++) begin
      tab[e] = k[7:0];
      e      = gf_xtime(e, poly);
    end
    return tab;
  endfunction

  // Reference product by shift-and-add; independent of the table method.
  function automatic gf_byte_t gf_mul_ref(input gf_byte_t a, input gf_byte_t b,
                                          input logic [8:0] poly);
    gf_byte_t acc;
    gf_byte_t aa;
    acc = 8'h00;
    aa  = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) begin
        acc = acc ^ aa;
      end
      aa = gf_xtime(aa, poly);
    end
    return acc;
  endfunction

endpackage : kuz_gf_pkg
`default_nettype wire

// File: rtl/gf256_mul_lane.sv
`default_nettype none
// ============================================================================
// Module      : gf256_mul_lane
// Description : One byte lane of the pipelined GF(2^8) multiplier.
//               S1 log lookup, S2 exponent add mod 255, S3 antilog lookup.
//               Pure datapath: stage load enables come from the parent.
// Revision    : 1.0 - initial release
// ============================================================================
module gf256_mul_lane
  import kuz_gf_pkg::*;
#(
  parameter logic [8:0] POLY = KUZ_POLY
) (
  input  logic     clk,
  input  logic     rst,
  input  logic     i_en1,
  input  logic     i_en2,
  input  logic     i_en3,
  input  gf_byte_t i_a,
  input  gf_byte_t i_b,
  output gf_byte_t o_p
);

  localparam gf_tab_t LOG_TAB = gf_log_tab(POLY);
  localparam gf_tab_t EXP_TAB = gf_exp_tab(POLY);

  gf_byte_t   r_la;
  gf_byte_t   r_lb;
  logic       r_z1;
  gf_byte_t   r_s;
  logic       r_z2;
  gf_byte_t   r_p;

  logic [8:0] w_sum;
  logic       w_wrap;
  gf_byte_t   w_mod;

  // Exponent add modulo 255. Logs are 0..254, so the sum is 0..508 and at
  // most one subtraction is needed. For s >= 255, s - 255 equals the low
  // byte of s + 1, which avoids a 9-bit subtractor.
  always_comb begin
    w_sum  = {1'b0, r_la} + {1'b0, r_lb};
    w_wrap = (w_sum >= 9'd255);
    w_mod  = w_sum[7:0] + {7'd0, w_wrap};
  end

  // S1: log lookups and zero detect
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_la <= '0;
      r_lb <= '0;
      r_z1 <= 1'b0;
    end else if (i_en1) begin
      r_la <= LOG_TAB[i_a];
      r_lb <= LOG_TAB[i_b];
      r_z1 <= (i_a == 8'h00) || (i_b == 8'h00);
    end
  end

  // S2: reduced exponent sum, zero flag carried
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s  <= '0;
      r_z2 <= 1'b0;
    end else if (i_en2) begin
      r_s  <= w_mod;
      r_z2 <= r_z1;
    end
  end

  // S3: antilog lookup, forced to zero when either operand was zero
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_p <= '0;
    end else if (i_en3) begin
      r_p <= r_z2 ? 8'h00 : EXP_TAB[r_s];
    end
  end

  assign o_p = r_p;

endmodule : gf256_mul_lane
`default_nettype wire

// File: rtl/gf256_mul_pipe.sv
`default_nettype none
// ============================================================================
// Module      : gf256_mul_pipe
// Description : LANES-wide pipelined GF(2^8) multiplier with valid/ready
//               handshake and full backpressure (no skid buffer; in_ready is
//               combinational from out_ready). Latency 3.
//               Optional build macro GF_XOR_REDUCE_EN adds an S4 stage that
//               registers out_sum = XOR of all lane products alongside out_p,
//               making latency 4.
// Revision    : 1.0 - initial release
// ============================================================================
module gf256_mul_pipe
  import kuz_gf_pkg::*;
#(
  parameter int         LANES = 16,
  parameter logic [8:0] POLY  = KUZ_POLY
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [8*LANES-1:0] in_a,
  input  logic [8*LANES-1:0] in_b,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [8*LANES-1:0] out_p
`ifdef GF_XOR_REDUCE_EN
  ,
  output logic [7:0]         out_sum
`endif
);

  // Stage occupancy flags
  logic r_v1;
  logic r_v2;
  logic r_v3;

  // Stage load enables: a stage may take new content when it is empty or
  // its current content moves on this edge.
  logic w_ld1;
  logic w_ld2;
  logic w_ld3;

  // Per-stage datapath enables: only load when a valid beat moves in, so
  // registers of idle stages keep their last value.
  logic w_en1;
  logic w_en2;
  logic w_en3;

  logic [8*LANES-1:0] w_p3;

`ifdef GF_XOR_REDUCE_EN
  logic               r_v4;
  logic               w_ld4;
  logic [8*LANES-1:0] r_p4;
  logic [7:0]         r_sum4;
  logic [7:0]         w_sum3;

  // The S4 register is the output stage; S3 drains into it.
  assign w_ld4 = !r_v4 || out_ready;
  assign w_ld3 = !r_v3 || w_ld4;
`else
  // S3 is the output stage.
  assign w_ld3 = !r_v3 || out_ready;
`endif

  assign w_ld2    = !r_v2 || w_ld3;
  assign w_ld1    = !r_v1 || w_ld2;
  assign in_ready = w_ld1;

  assign w_en1 = w_ld1 && in_valid;
  assign w_en2 = w_ld2 && r_v1;
  assign w_en3 = w_ld3 && r_v2;

  // Valid chain for S1..S3; reset discards every in-flight beat at once
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_v1 <= 1'b0;
      r_v2 <= 1'b0;
      r_v3 <= 1'b0;
    end else begin
      if (w_ld1) begin
        r_v1 <= in_valid;
      end
      if (w_ld2) begin
        r_v2 <= r_v1;
      end
      if (w_ld3) begin
        r_v3 <= r_v2;
      end
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < LANES; gi++) begin : g_lane
      gf256_mul_lane #(
        .POLY (POLY)
      ) u_lane (
        .clk   (clk),
        .rst   (rst),
        .i_en1 (w_en1),
        .i_en2 (w_en2),
        .i_en3 (w_en3),
        .i_a   (in_a[8*gi +: 8]),
        .i_b   (in_b[8*gi +: 8]),
        .o_p   (w_p3[8*gi +: 8])
      );
    end : g_lane
  endgenerate

`ifdef GF_XOR_REDUCE_EN
  // XOR reduction across all lane products of the S3 beat
  always_comb begin
    w_sum3 = 8'h00;
    for (int l = 0; l < LANES; l++) begin
      w_sum3 = w_sum3 ^ w_p3[8*l +: 8];
    end
  end

  // S4: output register holding products and their XOR sum together
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_v4   <= 1'b0;
      r_p4   <= '0;
      r_sum4 <= 8'h00;
    end else if (w_ld4) begin
      r_v4 <= r_v3;
      if (r_v3) begin
        r_p4   <= w_p3;
        r_sum4 <= w_sum3;
      end
    end
  end

  assign out_valid = r_v4;
  assign out_p     = r_p4;
  assign out_sum   = r_sum4;
`else
  assign out_valid = r_v3;
  assign out_p     = w_p3;
`endif

endmodule : gf256_mul_pipe
`default_nettype wire

// File: tb/tb_gf256_mul_pipe.sv
`default_nettype none
// ============================================================================
// Module      : tb_gf256_mul_pipe
// Description : Self-checking bench for gf256_mul_pipe: directed products,
//               lane independence, backpressure, reset mid-stream and an
//               exhaustive stream of all operand pairs against a scoreboard.
//               Honours GF_XOR_REDUCE_EN (out_sum, latency 4).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_gf256_mul_pipe;
  import kuz_gf_pkg::*;

  localparam int LANES = 16;
  localparam int W     = 8 * LANES;
`ifdef GF_XOR_REDUCE_EN
  localparam int LAT = 4;
`else
  localparam int LAT = 3;
`endif

  logic         clk;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_a;
  logic [W-1:0] in_b;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_p;
`ifdef GF_XOR_REDUCE_EN
  logic [7:0]   out_sum;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  int n_out    = 0;

  logic [W-1:0] q_p[$];
  logic [7:0]   q_s[$];

  gf256_mul_pipe #(
    .LANES (LANES),
    .POLY  (KUZ_POLY)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_p     (out_p)
`ifdef GF_XOR_REDUCE_EN
    ,
    .out_sum   (out_sum)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog got=no_finish exp=finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // One clock: observe handshakes at the falling edge, score drained beats,
  // record accepted beats, then return 1 time unit after the rising edge.
  task automatic tick(output bit acc, output bit rdy, output logic [W-1:0] pv);
    logic [W-1:0] e;
    logic [7:0]   s;
    @(negedge clk);
    acc = in_valid && in_ready;
    rdy = in_ready;
    pv  = out_p;
    if (out_valid && out_ready) begin
      if (q_p.size() == 0) begin
        chk("unexpected_beat", out_valid, 1'b0);
      end else begin
        chk("sb_p", out_p, q_p.pop_front());
`ifdef GF_XOR_REDUCE_EN
        chk("sb_sum", out_sum, q_s.pop_front());
`else
        void'(q_s.pop_front());
`endif
        n_out++;
      end
    end
    if (acc) begin
      e = '0;
      s = 8'h00;
      for (int l = 0; l < LANES; l++) begin
        e[8*l +: 8] = gf_mul_ref(in_a[8*l +: 8], in_b[8*l +: 8], KUZ_POLY);
        s           = s ^ e[8*l +: 8];
      end
      q_p.push_back(e);
      q_s.push_back(s);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic step();
    bit           a;
    bit           r;
    logic [W-1:0] p;
    tick(a, r, p);
  endtask

  // Count cycles (input cycle = 0) until out_valid, bounded.
  task automatic wait_out(input string tag, output int lat);
    lat = 1;
    while (!out_valid && lat < 12) begin
      step();
      lat++;
    end
    if (!out_valid) chk({tag, "_timeout"}, out_valid, 1'b1);
  endtask

  // Single beat on lane 0 with a hand-computed product; other lanes 0*0.
  task automatic single(input string tag, input gf_byte_t a0, input gf_byte_t b0,
                        input gf_byte_t exp0);
    bit           acc;
    bit           rdy;
    logic [W-1:0] pv;
    int           lat;
    in_a       = '0;
    in_b       = '0;
    in_a[7:0]  = a0;
    in_b[7:0]  = b0;
    in_valid   = 1'b1;
    out_ready  = 1'b1;
    tick(acc, rdy, pv);
    chk({tag, "_acc"}, acc, 1'b1);
    in_valid = 1'b0;
    wait_out(tag, lat);
    chk({tag, "_lat"}, lat, LAT);
    chk({tag, "_p0"}, out_p[7:0], exp0);
    step();
  endtask

  initial begin
    bit           acc;
    bit           rdy;
    logic [W-1:0] pv;
    logic [W-1:0] held;
    logic [W-1:0] expv;
    int           lat;
    int           sent;
    int           n_out0;
    int           nb;
    int           stall;
    int           idx;

    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    in_a      = '0;
    in_b      = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_out_p", out_p, '0);
`ifdef GF_XOR_REDUCE_EN
    chk("rst_out_sum", out_sum, 8'h00);
`endif
    rst = 1'b0;
    chk("rst_in_ready", in_ready, 1'b1);

    // Directed products
    single("mul_02_02", 8'h02, 8'h02, 8'h04);
    single("mul_80_02", 8'h80, 8'h02, 8'hC3);
    single("mul_03_03", 8'h03, 8'h03, 8'h05);
    single("mul_01_94", 8'h01, 8'h94, 8'h94);
    single("mul_00_ff", 8'h00, 8'hFF, 8'h00);
    single("mul_ff_00", 8'hFF, 8'h00, 8'h00);

    // Lane independence: a_i=i, b_i=1 except lane 5 where b=0
    expv = '0;
    for (int l = 0; l < LANES; l++) begin
      in_a[8*l +: 8] = 8'(l);
      in_b[8*l +: 8] = (l == 5) ? 8'h00 : 8'h01;
      expv[8*l +: 8] = (l == 5) ? 8'h00 : 8'(l);
    end
    in_valid = 1'b1;
    tick(acc, rdy, pv);
    in_valid = 1'b0;
    wait_out("lane_indep", lat);
    chk("lane_indep_p", out_p, expv);
`ifdef GF_XOR_REDUCE_EN
    chk("lane_indep_sum", out_sum, 8'h05);
`endif
    step();

`ifdef GF_XOR_REDUCE_EN
    // All lanes 0x02*0x02 = 0x04, sixteen copies XOR to zero
    in_a     = {LANES{8'h02}};
    in_b     = {LANES{8'h02}};
    in_valid = 1'b1;
    tick(acc, rdy, pv);
    in_valid = 1'b0;
    wait_out("sum_even", lat);
    chk("sum_even_lat", lat, 4);
    chk("sum_even", out_sum, 8'h00);
    step();
    single("sum_lane0", 8'h80, 8'h02, 8'hC3);
    in_a     = '0;
    in_b     = '0;
    in_a[7:0] = 8'h80;
    in_b[7:0] = 8'h02;
    in_valid = 1'b1;
    tick(acc, rdy, pv);
    in_valid = 1'b0;
    wait_out("sum_c3", lat);
    chk("sum_c3", out_sum, 8'hC3);
    step();
`endif

    // Backpressure: 10 beats, out_ready low for 5 cycles mid-stream
    sent   = 0;
    n_out0 = n_out;
    held   = '0;
    for (int t = 0; t < 40 && (sent < 10 || q_p.size() != 0); t++) begin
      out_ready = !(t >= LAT + 1 && t < LAT + 6);
      in_valid  = (sent < 10);
      for (int l = 0; l < LANES; l++) begin
        in_a[8*l +: 8] = 8'(sent * 16 + l + 1);
        in_b[8*l +: 8] = 8'(8'hA5 ^ (sent * 3 + l));
      end
      tick(acc, rdy, pv);
      if (t == LAT + 1) held = pv;
      if (t >= LAT + 1 && t < LAT + 6) chk("bp_in_ready", rdy, 1'b0);
      if (t >= LAT + 2 && t < LAT + 6) chk("bp_hold", pv, held);
      if (acc) sent++;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    chk("bp_sent", sent, 10);
    chk("bp_count", n_out - n_out0, 10);

    // Reset with three beats in flight
    for (int k = 0; k < 3; k++) begin
      in_a     = {LANES{8'(8'h31 + k)}};
      in_b     = {LANES{8'(8'h57 + k)}};
      in_valid = 1'b1;
      step();
    end
    in_valid = 1'b0;
    rst = 1'b1;
    #1;
    chk("rstmid_out_valid", out_valid, 1'b0);
    chk("rstmid_out_p", out_p, '0);
    q_p.delete();
    q_s.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      step();
      chk("rstmid_no_stale", out_valid, 1'b0);
    end
    single("post_rst", 8'h80, 8'h02, 8'hC3);

    // Exhaustive: every (a,b) pair, 16 pairs per beat, back-to-back
    nb        = 0;
    stall     = 0;
    out_ready = 1'b1;
    for (int t = 0; t < 4300 && nb < 4096; t++) begin
      for (int l = 0; l < LANES; l++) begin
        idx            = nb * 16 + l;
        in_a[8*l +: 8] = idx[15:8];
        in_b[8*l +: 8] = idx[7:0];
      end
      in_valid = 1'b1;
      tick(acc, rdy, pv);
      if (acc) nb++;
      else stall++;
    end
    in_valid = 1'b0;
    chk("exh_count", nb, 4096);
    chk("exh_stalls", stall, 0);
    for (int t = 0; t < 10 && q_p.size() != 0; t++) step();
    chk("exh_drain", q_p.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule : tb_gf256_mul_pipe
`default_nettype wire
